// File: rtl/mux8_rr_scheduler.sv
// Round-robin time-slice scheduler for an 8-input single-bit mux channel.
// Registered select/enable/grant with a one-cycle dead gap between owners.
module mux8_rr_scheduler #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] request,
  input  logic       done,
  output logic [2:0] select,
  output logic       enable,
  output logic [7:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] LOAD =
    COUNT_WIDTH'(HOLD_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [2:0]             sel_q, sel_d;
  logic [2:0]             last_q, last_d;
  logic                   en_q, en_d;
  logic [7:0]             gnt_q, gnt_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       term;

  // Scan upward from the slot after the last owner; k=8 lands on it last.
  always_comb begin
    win   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_q + 3'(k);
      if (!found && request[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign term = done
              | ~request[sel_q]
              | (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (|request) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = 8'd1 << win;
          en_d    = 1'b1;
          cnt_d   = LOAD;
        end else if (state_q == GAP) begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (term) begin
          state_d = GAP;
          en_d    = 1'b0;
          gnt_d   = '0;
          last_d  = sel_q;
        end else begin
          cnt_d = cnt_q - COUNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= 3'd7;
      en_q    <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign select = sel_q;
  assign enable = en_q;
  assign grant  = gnt_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench: two scheduler builds (hold 4 and hold 1) driven by shared stimulus
// and compared every cycle against a slot-level reference model.
module tb_mux8_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       dn;

  logic [2:0] sel4, sel1;
  logic       en4, en1;
  logic [7:0] gnt4, gnt1;
  logic       busy4, busy1;

  int n_tests;
  int n_fail;

  mux8_rr_scheduler #(
    .HOLD_CYCLES(4),
    .COUNT_WIDTH(8)
  ) u_h4 (
    .clock  (clk),
    .reset_n(rst_n),
    .request(req),
    .done   (dn),
    .select (sel4),
    .enable (en4),
    .grant  (gnt4),
    .busy   (busy4)
  );

  mux8_rr_scheduler #(
    .HOLD_CYCLES(1),
    .COUNT_WIDTH(8)
  ) u_h1 (
    .clock  (clk),
    .reset_n(rst_n),
    .request(req),
    .done   (dn),
    .select (sel1),
    .enable (en1),
    .grant  (gnt1),
    .busy   (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 idle, 1 owning the channel, 2 dead gap
  int m_mode[2];
  int m_sel[2];
  int m_last[2];
  int m_left[2];
  int m_hold[2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0;
      m_sel[d]  = 0;
      m_last[d] = 7;
      m_left[d] = 0;
    end
  endtask

  function automatic int pick(input int last, input logic [7:0] r);
    int c;
    for (int k = 1; k <= 8; k++) begin
      c = (last + k) % 8;
      if (r[c]) return c;
    end
    return last;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic d_in);
    for (int d = 0; d < 2; d++) begin
      if (m_mode[d] == 1) begin
        if (d_in || !r[m_sel[d]] || m_left[d] == 1) begin
          m_mode[d] = 2;
          m_last[d] = m_sel[d];
        end else begin
          m_left[d] = m_left[d] - 1;
        end
      end else if (r != 8'h00) begin
        m_sel[d]  = pick(m_last[d], r);
        m_left[d] = m_hold[d];
        m_mode[d] = 1;
      end else begin
        m_mode[d] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] eg;
    eg = (m_mode[0] == 1) ? (8'd1 << m_sel[0]) : 8'd0;
    check("h4_select", 32'(sel4),  32'(m_sel[0]));
    check("h4_enable", 32'(en4),   32'(m_mode[0] == 1));
    check("h4_grant",  32'(gnt4),  32'(eg));
    check("h4_busy",   32'(busy4), 32'(m_mode[0] != 0));
    eg = (m_mode[1] == 1) ? (8'd1 << m_sel[1]) : 8'd0;
    check("h1_select", 32'(sel1),  32'(m_sel[1]));
    check("h1_enable", 32'(en1),   32'(m_mode[1] == 1));
    check("h1_grant",  32'(gnt1),  32'(eg));
    check("h1_busy",   32'(busy1), 32'(m_mode[1] != 0));
  endtask

  task automatic cycle(input logic [7:0] r, input logic d_in);
    req = r;
    dn  = d_in;
    model_step(r, d_in);
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  logic [7:0] r;
  logic [7:0] mask;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    m_hold[0] = 4;
    m_hold[1] = 1;
    model_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    dn    = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    repeat (12) cycle(8'h08, 1'b0);
    async_reset();
    repeat (20) cycle(8'h81, 1'b0);
    repeat (14) cycle(8'h89, 1'b0);
    async_reset();

    repeat (3) cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b1);
    repeat (3) cycle(8'h20, 1'b0);
    cycle(8'h00, 1'b0);
    repeat (3) cycle(8'h04, 1'b0);
    repeat (4) cycle(8'h00, 1'b0);
    repeat (20) cycle(8'hFF, 1'b0);

    mask = 8'hFF;
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 0) begin
        r    = 8'($urandom);
        mask = r;
      end
      r = 8'($urandom) & mask;
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      if ($urandom_range(0, 3) != 0 && i > 0) r = req;
      cycle(r, $urandom_range(0, 7) == 0);
      if (i % 311 == 155) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
